// File: rtl/video_pkg.sv
// Shared pixel-stream types, frame geometry and colour-bar palette for the video pipeline.
package video_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef struct packed {
    logic   sop;
    logic   eop;
    pixel_t pixel;
  } stream_beat_t;

  // Left-to-right bar colours: white, yellow, cyan, green, magenta, red, blue, black.
  localparam pixel_t COLOUR_BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic pixel_t colour_bar_pixel(input int col, input int width);
    logic [2:0] bar;
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col >= i * (width / 8)) bar = 3'(i);
    end
    return COLOUR_BARS[bar];
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry ready/valid buffer for {sop, eop, pixel} beats; exposes occupancy for credit-based upstream issue.
module stream_skid_buffer
  import video_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  stream_beat_t in_beat,
  input  logic         out_ready,
  output logic         out_valid,
  output stream_beat_t out_beat,
  output logic [1:0]   occupancy
);

  stream_beat_t head_q, head_d;
  stream_beat_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign out_valid = (count_q != 2'd0);
  assign out_beat  = head_q;
  assign occupancy = count_q;
  assign pop       = out_valid && out_ready;

  // Head always holds the oldest beat so the output is stable while stalled.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_beat;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_beat;
        end else if (in_valid) begin
          tail_d  = in_beat;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid) tail_d = in_beat;
          else          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Reads a stored frame in raster order and emits it as one sop/eop-framed ready/valid packet.
// FRAME_READER_TEST_PATTERN_EN adds a pattern_en input that substitutes internally generated colour bars.
module frame_stream_reader
  import video_pkg::*;
#(
  parameter int IMAGE_WIDTH  = video_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = video_pkg::IMAGE_HEIGHT,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FRAME_READER_TEST_PATTERN_EN
  input  logic              pattern_en,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_rdata,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [11:0]       data_out
);

  // state  | meaning
  // IDLE   | waiting for start, outputs idle
  // STREAM | issuing reads and transferring pixels
  // DONE   | one-cycle frame_done pulse
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int N     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             pend_sop_q, pend_sop_d;
  logic             pend_eop_q, pend_eop_d;

  logic             rd_issue;
  logic             pop;
  logic [2:0]       credit_used;
  logic [1:0]       occupancy;
  pixel_t           src_pix;
  stream_beat_t     in_beat, out_beat;

`ifdef FRAME_READER_TEST_PATTERN_EN
  localparam int COL_W = $clog2(IMAGE_WIDTH);
  logic             pattern_q, pattern_d;
  logic [COL_W-1:0] col_q, col_d;
  pixel_t           bar_pix_q, bar_pix_d;

  assign src_pix   = pattern_q ? bar_pix_q : pixel_t'(mem_rdata);
  assign mem_rd_en = rd_issue && !pattern_q;
`else
  assign src_pix   = pixel_t'(mem_rdata);
  assign mem_rd_en = rd_issue;
`endif

  // Read data lands in the buffer one cycle after the strobe, so a read issued
  // last cycle counts against the two buffer slots until it is pushed.
  assign pop         = valid_out && ready_in;
  assign credit_used = 3'(occupancy) + 3'(rd_pend_q);
  assign rd_issue    = (state_q == STREAM) && (rd_cnt_q != CNT_END) &&
                       (credit_used < (3'd2 + 3'(pop)));

  assign mem_addr   = rd_cnt_q[ADDR_W-1:0];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_beat    = {pend_sop_q, pend_eop_q, src_pix};

  stream_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pend_q),
    .in_beat   (in_beat),
    .out_ready (ready_in),
    .out_valid (valid_out),
    .out_beat  (out_beat),
    .occupancy (occupancy)
  );

  assign startofpacket_out = valid_out && out_beat.sop;
  assign endofpacket_out   = valid_out && out_beat.eop;
  assign data_out          = out_beat.pixel;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    rd_pend_d    = rd_issue;
    pend_sop_d   = pend_sop_q;
    pend_eop_d   = pend_eop_q;
    if (rd_issue) begin
      pend_sop_d = (rd_cnt_q == '0);
      pend_eop_d = (rd_cnt_q == CNT_LAST);
      rd_cnt_d   = rd_cnt_q + CNT_W'(1);
    end
`ifdef FRAME_READER_TEST_PATTERN_EN
    pattern_d = pattern_q;
    col_d     = col_q;
    bar_pix_d = bar_pix_q;
    if (rd_issue) begin
      bar_pix_d = colour_bar_pixel(int'(col_q), IMAGE_WIDTH);
      col_d     = (col_q == COL_W'(IMAGE_WIDTH - 1)) ? '0 : col_q + COL_W'(1);
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          busy_d   = 1'b1;
          rd_cnt_d = '0;
`ifdef FRAME_READER_TEST_PATTERN_EN
          pattern_d = pattern_en;
          col_d     = '0;
`endif
        end
      end
      STREAM: begin
        if (pop && endofpacket_out) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_cnt_q     <= '0;
      rd_pend_q    <= 1'b0;
      pend_sop_q   <= 1'b0;
      pend_eop_q   <= 1'b0;
`ifdef FRAME_READER_TEST_PATTERN_EN
      pattern_q    <= 1'b0;
      col_q        <= '0;
      bar_pix_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_pend_q    <= rd_pend_d;
      pend_sop_q   <= pend_sop_d;
      pend_eop_q   <= pend_eop_d;
`ifdef FRAME_READER_TEST_PATTERN_EN
      pattern_q    <= pattern_d;
      col_q        <= col_d;
      bar_pix_q    <= bar_pix_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_stream_reader.sv
// Self-checking bench for frame_stream_reader: packet-level reference model plus hand-computed literals.
// Uses a 320x4 frame so several complete frames fit in a short run.
module tb_frame_stream_reader;

  localparam int W  = 320;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready_in = 1'b0;
  logic          busy, frame_done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_rdata = 12'h000;
  logic          valid_out, sop, eop;
  logic [11:0]   data_out;
  bit            pat_req = 1'b0;
`ifdef FRAME_READER_TEST_PATTERN_EN
  logic          pattern_en = 1'b0;
`endif

  frame_stream_reader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
`ifdef FRAME_READER_TEST_PATTERN_EN
    .pattern_en        (pattern_en),
`endif
    .busy              (busy),
    .frame_done        (frame_done),
    .mem_rd_en         (mem_rd_en),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .startofpacket_out (sop),
    .endofpacket_out   (eop),
    .data_out          (data_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame buffer whose word a holds a[11:0].
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[11:0];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int idx, input bit pat);
    logic [11:0] bars [8];
    int v;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (pat) return bars[(idx % W) / (W / 8)];
    v = idx;
    return v[11:0];
  endfunction

  typedef enum {M_IDLE, M_STREAM, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  int          m_idx = 0, m_rd = 0, m_cyc = 0;
  bit          m_pattern = 1'b0, model_on = 1'b0, rst_prev = 1'b0, stall_prev = 1'b0;
  logic [11:0] stall_data = 12'h000;
  logic        stall_sop = 1'b0, stall_eop = 1'b0;
  int          first_valid_cyc = -1, done_cyc = -1, eop_count = 0, frame_count = 0;
  logic [11:0] eop_data = 12'h000;
  logic [11:0] cap [512];

  always @(negedge clk) begin
    if (model_on) begin
      if (rst_prev) begin
        chk("rst_ctrl_outputs", {26'd0, busy, frame_done, mem_rd_en, valid_out, sop, eop}, 32'd0);
        chk("rst_addr_data", {mem_addr, data_out}, 32'd0);
      end else begin
        chk("busy", busy, m_state == M_STREAM);
        chk("frame_done", frame_done, m_state == M_DONE);
        if (m_state != M_STREAM) begin
          chk("idle_valid", valid_out, 0);
          chk("idle_rd_en", mem_rd_en, 0);
        end
        if (stall_prev)
          chk("stall_hold", {valid_out, sop, eop, data_out}, {1'b1, stall_sop, stall_eop, stall_data});
        if (valid_out) begin
          chk("data", data_out, exp_pix(m_idx, m_pattern));
          chk("sop", sop, m_idx == 0);
          chk("eop", eop, m_idx == N - 1);
          if (m_idx == 0 && !stall_prev) first_valid_cyc = m_cyc;
        end else begin
          chk("framing_without_valid", {sop, eop}, 0);
        end
        if (mem_rd_en) begin
          chk("rd_in_pattern_mode", m_pattern, 0);
          chk("rd_addr", mem_addr, m_rd);
          chk("rd_past_end", m_rd < N, 1);
        end
      end
    end
    if (!rst_n) begin
      m_state = M_IDLE; m_idx = 0; m_rd = 0; stall_prev = 1'b0; model_on = 1'b1;
    end else if (model_on) begin
      stall_prev = valid_out && !ready_in;
      stall_data = data_out; stall_sop = sop; stall_eop = eop;
      if (mem_rd_en) m_rd++;
      case (m_state)
        M_IDLE: if (start) begin
          m_state = M_STREAM; m_idx = 0; m_rd = 0; m_cyc = 1; m_pattern = pat_req;
        end
        M_STREAM: begin
          if (valid_out && ready_in) begin
            if (m_idx < 512) cap[m_idx] = data_out;
            if (eop) begin eop_count++; eop_data = data_out; end
            m_idx++;
            if (m_idx == N) m_state = M_DONE;
          end
          chk("outstanding_le_2", (m_rd - m_idx) <= 2, 1);
          m_cyc++;
        end
        default: begin
          done_cyc = m_cyc; frame_count++; m_state = M_IDLE;
        end
      endcase
    end
    rst_prev = !rst_n;
  end

  task automatic run_frame(input bit rnd, input int start_at, input bit pat);
    int cyc;
    bit pulsed, ok;
    cyc = 0; pulsed = 1'b0; ok = 1'b0;
    @(posedge clk); #1;
    pat_req = pat;
`ifdef FRAME_READER_TEST_PATTERN_EN
    pattern_en = pat;
`endif
    start = 1'b1;
    ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3 * N + 50) begin
      if (frame_done) begin ok = 1'b1; break; end
      ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pulsed && start_at >= 0 && m_idx >= start_at) begin start = 1'b1; pulsed = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; ready_in = 1'b1;
    chk("frame_completed", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int e0, f0, cyc;
    rst_n = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
    end
    start = 1'b0; ready_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    run_frame(1'b0, -1, 1'b0);
    chk("f1_first_valid_cycle", first_valid_cyc, 3);
    chk("f1_done_cycle", done_cyc, 1283);
    chk("f1_eop_count", eop_count, 1);
    chk("f1_frames", frame_count, 1);
    chk("f1_pixel0", cap[0], 12'h000);
    chk("f1_pixel300", cap[300], 12'h12C);
    chk("f1_last_pixel", eop_data, 12'h4FF);

    run_frame(1'b1, 500, 1'b0);
    chk("f2_eop_count", eop_count, 2);
    chk("f2_frames", frame_count, 2);
    chk("f2_first_valid_cycle", first_valid_cyc, 3);
    chk("f2_pixel511", cap[511], 12'h1FF);

    run_frame(1'b0, -1, 1'b0);
    chk("f3_frames", frame_count, 3);
    chk("f3_done_cycle", done_cyc, 1283);

    e0 = eop_count; f0 = frame_count;
    @(posedge clk); #1;
    start = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (m_idx < 1000 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("f4_reached_pixel_1000", m_idx, 1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("f4_no_eop_after_abort", eop_count, e0);
    chk("f4_no_frame_done_after_abort", frame_count, f0);
    run_frame(1'b0, -1, 1'b0);
    chk("f5_first_valid_cycle", first_valid_cyc, 3);
    chk("f5_eop_count", eop_count, e0 + 1);
    chk("f5_pixel0", cap[0], 12'h000);

`ifdef FRAME_READER_TEST_PATTERN_EN
    run_frame(1'b1, -1, 1'b1);
    chk("pat_pixel0", cap[0], 12'hFFF);
    chk("pat_pixel40", cap[40], 12'hFF0);
    chk("pat_pixel319", cap[319], 12'h000);
    chk("pat_pixel320", cap[320], 12'hFFF);
    chk("pat_last_pixel", eop_data, 12'h000);
    run_frame(1'b0, -1, 1'b0);
    chk("mem_after_pat_pixel40", cap[40], 12'h028);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_stream_reader.md
# frame_stream_reader

Streaming video source that reads a stored 320x240 RGB444 frame from a synchronous-read frame buffer and emits it as a ready/valid pixel stream with start/end-of-packet framing. It is the producer side of the pixel-stream interface that the filter chain (blur, colour effects) consumes: its outputs connect directly to a filter's `valid_in`/`data_in`/`startofpacket_in`/`endofpacket_in`, and the filter's `ready_out` connects to this block's `ready_in`. One frame is one packet; transfers are fully backpressure-safe.

## Interface
Parameters:
- `IMAGE_WIDTH`, 320: pixels per line.
- `IMAGE_HEIGHT`, 240: lines per frame.
- `ADDR_W`, 17: frame-buffer address width; must satisfy 2^ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request one frame; sampled only in IDLE.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the last pixel transfers.
- `mem_rd_en` out 1: frame-buffer read strobe.
- `mem_addr` out ADDR_W: raster address, `line*IMAGE_WIDTH + col`.
- `mem_rdata` in 12: read data, valid exactly 1 cycle after `mem_rd_en`.
- `ready_in` in 1: downstream ready (ready latency 0).
- `valid_out` out 1: `data_out` holds a pixel.
- `startofpacket_out` out 1: first pixel of the frame.
- `endofpacket_out` out 1: last pixel of the frame.
- `data_out` out 12: {R[11:8], G[7:4], B[3:0]}.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE: outputs idle. `start`=1 → STREAM; read counter and transfer counter cleared to 0.
- STREAM: reads are issued in raster order, addresses 0..N-1, where N = IMAGE_WIDTH*IMAGE_HEIGHT. A read is issued in a cycle only if (buffer occupancy + reads in flight − pops this cycle) < 2, so the 2-entry output buffer never overflows. No reads are issued after address N-1.
- Transfer: a pixel transfers when `valid_out && ready_in`. While `valid_out && !ready_in`, `data_out`, `startofpacket_out`, and `endofpacket_out` hold stable.
- `startofpacket_out`=1 only with pixel 0; `endofpacket_out`=1 only with pixel N-1; both are 0 whenever `valid_out`=0.
- A transfer of pixel N-1 moves the FSM to DONE. DONE lasts 1 cycle: `frame_done`=1, `busy`=0, then the FSM returns to IDLE.
- `start` in STREAM or DONE is ignored (not queued).
- Pixel data is passed through unmodified; no arithmetic on colour.

## Timing
- Reset values: `busy`, `frame_done`, `mem_rd_en`, `valid_out`, `startofpacket_out`, `endofpacket_out` = 0; `mem_addr`, `data_out` = 0; FSM = IDLE; buffer empty.
- Reset mid-frame: the partial frame is abandoned, with no `endofpacket_out`. The next `start` restarts at pixel 0 with `startofpacket_out`.
- Latency: `start` sampled high at edge 0 → `busy`=1 and `mem_rd_en`=1, `mem_addr`=0 in cycle 1 → `mem_rdata` in cycle 2 → `valid_out`=1 with pixel 0 in cycle 3.
- Throughput: 1 pixel/cycle with `ready_in` held high. A full frame takes N+3 cycles from `start` to `frame_done`.
- `ready_in` deasserted for k cycles stalls output for exactly k cycles. No loss and no duplication.
- `busy` is high from the cycle after `start` through the cycle of the last transfer.

## Configuration
- `FRAME_READER_TEST_PATTERN_EN` defined: adds input `pattern_en` (1 bit), sampled with `start`.
  - If `pattern_en`=1, the frame is internally generated colour bars: 8 vertical bars, each IMAGE_WIDTH/8 wide. Colours left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - In pattern mode, `mem_rd_en` stays 0; framing, handshake, and latency are identical to memory mode.
- Not defined: no `pattern_en` port; frames always come from memory.

## Structure
- Shared package `video_pkg`: `IMAGE_WIDTH`/`IMAGE_HEIGHT` constants, `pixel_t` (12-bit packed RGB444 struct), `FRAME_PIXELS`, and the colour-bar constant array. The filter blocks use the same package.
- Sub-module `stream_skid_buffer`: 2-entry ready/valid buffer carrying {sop, eop, pixel}. It exposes occupancy so the read issuer can apply the credit rule.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0. After release, with `start`=0, `valid_out` stays 0.
- Full frame, `ready_in`=1, memory word[a]=a[11:0]: `start` → first `valid_out` in cycle 3. 76800 transfers, each `data_out`=index[11:0]. sop only on pixel 0, eop only on pixel 76799. `frame_done` pulses at cycle 76803.
- Random 50% `ready_in` backpressure → identical pixel sequence. Outputs stable during every stall. Never more than 2 reads outstanding plus buffered.
- Pulse `start` at pixel 500 of a frame → ignored, one eop only. `start` after `frame_done` → a second complete frame.
- `rst_n`=0 for 1 cycle at pixel 1000 → all outputs 0 next cycle, no eop. New `start` → pixel 0 with sop, `mem_addr`=0.
- Macro defined, `pattern_en`=1 → pixel 0=FFF, pixel 40=FF0, pixel 319=000, pixel 320=FFF. `mem_rd_en` never asserted.
